// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage: word width, NOP
// encoding, default reset PC and fetch FSM state encodings.
package instr_fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

   localparam logic [1:0] FETCH_IDLE = 2'd0;
   localparam logic [1:0] FETCH_REQ  = 2'd1;
   localparam logic [1:0] FETCH_HOLD = 2'd2;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time over
// a req/ack port and hands {instr, pc} to decode with valid/ready.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               mem_req,
   output logic [31:0]        mem_addr,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        pc
);

   logic [1:0]  state;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic        drop;
   logic [31:0] target;

   assign target   = word_align(redirect_pc);
   assign mem_req  = (state == FETCH_REQ);
   assign mem_addr = addr_q;

   // NOTE: reset is sampled on the clock edge, so it lives inside the
   // clocked block; all state updates use non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= FETCH_IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         drop        <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= INSTR_NOP;
         pc          <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q        <= target;
         instr_valid <= 1'b0;
         case (state)
            FETCH_REQ: begin
               if (mem_ack) begin
                  // Outstanding request completes now: its data is dropped
                  // and the new fetch can issue immediately.
                  addr_q <= target;
                  drop   <= 1'b0;
               end else begin
                  // Address must stay stable until the ack; the eventual
                  // data is discarded.
                  drop <= 1'b1;
               end
               state <= FETCH_REQ;
            end
            default: begin
               addr_q <= target;
               state  <= FETCH_REQ;
            end
         endcase
      end else begin
         case (state)
            FETCH_IDLE: begin
               addr_q <= pc_q;
               state  <= FETCH_REQ;
            end
            FETCH_REQ: begin
               if (mem_ack) begin
                  if (drop) begin
                     drop   <= 1'b0;
                     addr_q <= pc_q;
                  end else begin
                     instr       <= mem_rdata;
                     pc          <= pc_q;
                     instr_valid <= 1'b1;
                     state       <= FETCH_HOLD;
                  end
               end
            end
            FETCH_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  pc_q        <= pc_q + 32'd4;
                  addr_q      <= pc_q + 32'd4;
                  state       <= FETCH_REQ;
               end
            end
            default: state <= FETCH_IDLE;
         endcase
      end
   end

endmodule
